// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain with skid buffers, flush and occupancy.
// Optional stall counter port enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]                    stall_cycles,
`endif
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] sv;
  logic [WIDTH-1:0] md [DEPTH];
  logic [WIDTH-1:0] sd [DEPTH];

  // Link k feeds stage k; link DEPTH is the chain output.
  logic [DEPTH:0]   uv;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] ud [DEPTH+1];

  logic in_fire;
  logic out_fire;

  always_comb begin
    uv[0]      = in_valid;
    ud[0]      = in_data;
    rdy[DEPTH] = out_ready;
    for (int k = 0; k < DEPTH; k++) begin
      uv[k+1] = mv[k];
      ud[k+1] = md[k];
      rdy[k]  = ~sv[k];
    end
    rdy[0] = reset & ~sv[0];
  end

  assign in_ready  = rdy[0];
  assign out_valid = uv[DEPTH];
  assign out_data  = ud[DEPTH];
  assign in_fire   = in_valid & rdy[0];
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mv <= '0;
      sv <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        md[k] <= '0;
        sd[k] <= '0;
      end
    end else if (flush) begin
      mv <= '0;
      sv <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        // Main frees up: skid (older) wins over upstream.
        if (!mv[k] || rdy[k+1]) begin
          if (sv[k]) begin
            mv[k] <= 1'b1;
            md[k] <= sd[k];
            sv[k] <= 1'b0;
          end else begin
            mv[k] <= uv[k] & rdy[k];
            if (uv[k] & rdy[k])
              md[k] <= ud[k];
          end
        end else if (uv[k] & rdy[k]) begin
          sv[k] <= 1'b1;
          sd[k] <= ud[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      occupancy <= '0;
    else if (flush)
      occupancy <= '0;
    else
      occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles <= '0;
    else if (out_valid && !out_ready && !(&stall_cycles))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed DEPTH=2 checks, random DEPTH=3 run.
// Queue-based reference model; PIPE_STAGE_PERF_EN adds stall counter checks.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fl2, iv2, ir2, ov2, or2;
  logic [63:0] id2, od2;
  logic [2:0]  occ2;
  logic        fl3, iv3, ir3, ov3, or3;
  logic [63:0] id3, od3;
  logic [2:0]  occ3;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] st2, st3;
`endif

  pipe_stage_chain #(.WIDTH(64), .DEPTH(2)) d2 (
    .clk(clk), .reset(reset), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cycles(st2),
`endif
    .occupancy(occ2)
  );

  pipe_stage_chain #(.WIDTH(64), .DEPTH(3)) d3 (
    .clk(clk), .reset(reset), .flush(fl3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cycles(st3),
`endif
    .occupancy(occ3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int stl    = 0;
  logic [63:0] q2[$];
  logic [63:0] q3[$];
  logic [63:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the DEPTH=2 chain; called at a negedge.
  task automatic cyc2(input logic v, input logic [63:0] d,
                      input logic r, input logic f);
    logic inf, outf;
    iv2 = v; id2 = d; or2 = r; fl2 = f;
    inf  = v & ir2;
    outf = ov2 & r;
    if (ov2 && !r) stl++;
    if (outf && q2.size() > 0) begin
      got.push_back(od2);
      void'(q2.pop_front());
    end
    if (inf) q2.push_back(d);
    if (f) q2.delete();
    @(negedge clk);
    chk("occ2", 64'(occ2), 64'(q2.size()));
    if (q2.size() > 0) begin
      if (ov2) chk("head2", od2, q2[0]);
    end else begin
      chk("ov2_empty", 64'(ov2), 64'd0);
    end
    if (q2.size() == 4) chk("full_ir2", 64'(ir2), 64'd0);
  endtask

  task automatic cyc3(input logic v, input logic [63:0] d,
                      input logic r, input logic f);
    logic inf, outf;
    iv3 = v; id3 = d; or3 = r; fl3 = f;
    inf  = v & ir3;
    outf = ov3 & r;
    if (outf && q3.size() > 0) void'(q3.pop_front());
    if (inf) q3.push_back(d);
    if (f) q3.delete();
    @(negedge clk);
    chk("occ3", 64'(occ3), 64'(q3.size()));
    if (q3.size() > 0) begin
      if (ov3) chk("head3", od3, q3[0]);
    end else begin
      chk("ov3_empty", 64'(ov3), 64'd0);
    end
    if (q3.size() == 6) chk("full_ir3", 64'(ir3), 64'd0);
  endtask

  initial begin
    int acc;
    logic a;
    logic [63:0] nv;

    reset = 1'b0;
    iv2 = 1'b1; id2 = 64'hDEAD; or2 = 1'b0; fl2 = 1'b0;
    iv3 = 1'b1; id3 = 64'hDEAD; or3 = 1'b0; fl3 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ir2", 64'(ir2), 64'd0);
      chk("rst_ov2", 64'(ov2), 64'd0);
      chk("rst_od2", od2, 64'd0);
      chk("rst_occ2", 64'(occ2), 64'd0);
      chk("rst_od3", od3, 64'd0);
    end
    iv2 = 1'b0; iv3 = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_ir2", 64'(ir2), 64'd1);
    @(negedge clk);
    chk("rel_ir2b", 64'(ir2), 64'd1);
    chk("rel_ov2", 64'(ov2), 64'd0);
    chk("rel_ir3", 64'(ir3), 64'd1);

    // Streaming 1..8 at full rate.
    got.delete();
    cyc2(1'b1, 64'd1, 1'b1, 1'b0);
    chk("lat_first", 64'(ov2), 64'd0);
    cyc2(1'b1, 64'd2, 1'b1, 1'b0);
    chk("lat_second", 64'(ov2), 64'd1);
    chk("lat_data", od2, 64'd1);
    for (int i = 3; i <= 8; i++) begin
      cyc2(1'b1, 64'(i), 1'b1, 1'b0);
      chk("occ_steady", 64'(occ2), 64'd2);
      chk("ov_steady", 64'(ov2), 64'd1);
    end
    repeat (4) cyc2(1'b0, 64'd0, 1'b1, 1'b0);
    chk("stream_cnt", 64'(got.size()), 64'd8);
    for (int i = 0; i < got.size(); i++)
      chk("stream_val", got[i], 64'(i + 1));

    // Backpressure absorbs exactly 4 entries.
    got.delete();
    nv = 64'hA0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      a = ir2;
      cyc2(1'b1, nv, 1'b0, 1'b0);
      if (a) begin
        nv++;
        acc++;
      end
    end
    chk("bp_acc", 64'(acc), 64'd4);
    chk("bp_occ", 64'(occ2), 64'd4);
    chk("bp_ir", 64'(ir2), 64'd0);
    chk("bp_hold", od2, 64'hA0);
    repeat (6) cyc2(1'b0, 64'd0, 1'b1, 1'b0);
    chk("bp_cnt", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size(); i++)
      chk("bp_val", got[i], 64'hA0 + 64'(i));

    // Flush with three entries held and a handshake in the flush cycle.
    cyc2(1'b1, 64'h31, 1'b0, 1'b0);
    cyc2(1'b1, 64'h32, 1'b0, 1'b0);
    cyc2(1'b1, 64'h33, 1'b0, 1'b0);
    chk("fl_pre_occ", 64'(occ2), 64'd3);
    cyc2(1'b1, 64'h55, 1'b0, 1'b1);
    chk("fl_occ", 64'(occ2), 64'd0);
    chk("fl_ov", 64'(ov2), 64'd0);
    chk("fl_ir", 64'(ir2), 64'd1);
    got.delete();
    repeat (5) begin
      cyc2(1'b0, 64'd0, 1'b1, 1'b0);
      chk("fl_quiet", 64'(ov2), 64'd0);
    end
    chk("fl_none", 64'(got.size()), 64'd0);

    // Random handshakes on the DEPTH=3 chain.
    for (int i = 0; i < 10000; i++)
      cyc3(1'($urandom_range(1)), {$urandom, $urandom},
           1'($urandom_range(1)), $urandom_range(255) == 0);
    repeat (12) cyc3(1'b0, 64'd0, 1'b1, 1'b0);
    chk("rnd_empty", 64'(q3.size()), 64'd0);
    chk("rnd_occ", 64'(occ3), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    reset = 1'b0;
    iv2 = 1'b0; iv3 = 1'b0; or2 = 1'b0; fl2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q2.delete();
    q3.delete();
    chk("perf_rst0", 64'(st2), 64'd0);
    stl = 0;
    cyc2(1'b1, 64'h77, 1'b0, 1'b0);
    for (int i = 0; i < 40 && stl < 17; i++)
      cyc2(1'b0, 64'd0, 1'b0, 1'b0);
    chk("perf_17", 64'(st2), 64'd17);
    cyc2(1'b0, 64'd0, 1'b1, 1'b1);
    chk("perf_flush", 64'(st2), 64'd17);
    reset = 1'b0;
    @(negedge clk);
    chk("perf_rst", 64'(st2), 64'd0);
    reset = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
